// File: rtl/pixel_stream_pkg.sv
// Shared types for the raster pixel source: sideband flags that travel with
// each pixel and the source sequencer states.
package pixel_stream_pkg;

    localparam int PIX_W_DEF = 24;

    typedef struct packed {
        logic sof;
        logic eof;
        logic sol;
        logic eol;
    } pix_flags_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        DONE
    } src_state_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry first-word-fall-through register FIFO; head is always entry 0,
// so the output is valid straight from registers whenever count is non-zero.
module pix_skid_fifo #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign head   = entry0;

    // NOTE: the storage is reset too, because the head drives the pixel and
    // flag outputs directly and those must read zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && count == 2'd2));

endmodule

// File: rtl/pixel_stream_source.sv
// Streams one frame from a synchronous-read frame RAM in raster order, with
// valid/ready handshake and start/end of line/frame flags per pixel.
module pixel_stream_source
    import pixel_stream_pkg::*;
#(
    parameter  int H_RES  = 640,
    parameter  int V_RES  = 480,
    parameter  int PIX_W  = PIX_W_DEF,
    localparam int ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  out_pix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_sol,
    output logic              out_eol
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int E_W = $bits(pix_flags_t) + PIX_W;

    localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);

    src_state_t      state;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic            inflight;
    pix_flags_t      issue_flags;
    pix_flags_t      pend_flags;
    pix_flags_t      head_flags;
    logic [E_W-1:0]  fifo_head;
    logic [1:0]      fifo_count;
    logic            pop;
    logic [2:0]      occupancy;
    logic            drain_empty;

    assign busy      = (state != IDLE);
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;

    // Occupancy counts the pixel leaving this cycle as already gone, which is
    // what lets a read issue every cycle while downstream keeps accepting.
    assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign mem_rd_en = (state == ACTIVE) && (occupancy < 3'd2);

    assign drain_empty = !inflight &&
                         ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));

    always_comb begin
        issue_flags = '{sof: (x == '0) && (y == '0),
                        eof: (x == X_LAST) && (y == Y_LAST),
                        sol: (x == '0),
                        eol: (x == X_LAST)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            mem_addr <= '0;
            x        <= '0;
            y        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACTIVE;
                        mem_addr <= '0;
                        x        <= '0;
                        y        <= '0;
                    end
                end
                ACTIVE: begin
                    if (mem_rd_en) begin
                        if (mem_addr == ADDR_LAST) begin
                            state <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= y + Y_W'(1);
                            end else begin
                                x <= x + X_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Flags ride one cycle behind the read so they meet their RAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= 1'b0;
            pend_flags <= '0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) pend_flags <= issue_flags;
        end
    end

    pix_skid_fifo #(
        .W (E_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({pend_flags, mem_rdata}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign {head_flags, out_pix} = fifo_head;
    assign out_sof = head_flags.sof;
    assign out_eof = head_flags.eof;
    assign out_sol = head_flags.sol;
    assign out_eol = head_flags.eol;

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Raster pixel producer feeding the edge-detection pixel stream.
- On a start pulse, reads one frame from a synchronous-read frame RAM in raster order (x fastest).
- Emits 24-bit pixels with valid/ready handshake plus start/end-of-line and start/end-of-frame flags, so downstream filters can reset neighbour history at line boundaries.
- Sits between the frame buffer and the per-pixel filter chain.

Parameters:
- H_RES, 640, active pixels per line (>=2).
- V_RES, 480, lines per frame (>=1).
- PIX_W, 24, pixel width in bits.
- ADDR_W, $clog2(H_RES*V_RES), derived localparam; frame RAM address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to stream one frame; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pixel is handshaken.
- mem_rd_en  out  1  frame RAM read strobe.
- mem_addr  out  ADDR_W  frame RAM read address, valid when mem_rd_en is high.
- mem_rdata  in  PIX_W  RAM data, valid exactly one cycle after mem_rd_en.
- out_pix  out  PIX_W  pixel data.
- out_valid  out  1  pixel and flags valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_sof  out  1  pixel (0,0).
- out_eof  out  1  pixel (H_RES-1,V_RES-1).
- out_sol  out  1  x==0.
- out_eol  out  1  x==H_RES-1.

Behaviour:
- Reset (async, any time incl. mid-frame) forces outputs to 0: busy, done, mem_rd_en, mem_addr, out_valid, out_pix, and all four flags.
- Reset also returns the FSM to IDLE, clears the FIFO and in-flight counter, and discards any RAM data returning after reset.
- FSM states:
  - IDLE: start=1 -> ACTIVE; address counter = 0; x = 0; y = 0.
  - ACTIVE: issues reads; when the last address (H_RES*V_RES-1) has been issued -> DRAIN.
  - DRAIN: no reads; when the FIFO is empty and nothing is in flight -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy = (state != IDLE).
- Read issue rule: in ACTIVE, mem_rd_en=1 when (fifo_count + inflight - pop) < 2, where pop = out_valid && out_ready in that cycle.
  - mem_addr increments by 1 per issued read; addresses are generated incrementally (no multiplier).
  - x/y counters advance with each issued read; x wraps at H_RES-1 to 0 and increments y.
- Flags are computed from x/y at issue time and carried through the pipeline alongside the data.
- inflight: 1-bit register = mem_rd_en of the previous cycle. When inflight=1, mem_rdata plus the pending flags are pushed into the FIFO at the rising edge.
- FIFO: 2-entry, first-word-fall-through from registers.
  - out_valid = (fifo_count != 0).
  - out_pix and flags are driven from the head entry.
  - Push and pop in the same cycle are both honoured.
  - The issue rule guarantees no overflow; an overflow is a design error (assertion).
- Latency: start sampled high at edge t -> first mem_rd_en in cycle t+1 -> out_valid high in cycle t+3.
- Throughput: 1 pixel/clk sustained while out_ready=1.
- Backpressure:
  - With out_ready=0, out_valid and out_pix/flags hold stable until accepted.
  - Reads stop once occupancy reaches 2.
  - No pixel is dropped or duplicated.
- start while busy: ignored, no effect on the current frame. start in the DONE cycle: ignored.
- done pulses in the cycle after the out_eof handshake, then the FSM goes to IDLE.
- V_RES=1: out_sof and out_eof mark the first and last pixels of the single line.

Decomposition:
- Package pixel_stream_pkg holds:
  - typedef struct packed {sof, eof, sol, eol} pix_flags_t;
  - enum src_state_t {IDLE, ACTIVE, DRAIN, DONE};
  - PIX_W default constant.
- Sub-module pix_skid_fifo, parameterized on width:
  - 2-entry FWFT register FIFO storing {pix_flags_t, pixel}.
  - Ports: push, push_data, pop, head, count.

Test Plan (H_RES=4, V_RES=2, RAM model with mem[a]=a*24'h010101, 1-cycle read latency):
- Basic frame: start pulse at t, out_ready=1 -> first out_valid at t+3, then 8 consecutive pixels 000000..070707.
  - Flags: sof on pixel 0; sol on 0 and 4; eol on 3 and 7; eof on 7.
  - done pulses 1 cycle after pixel 7; busy clears the same cycle done falls.
- Backpressure: out_ready toggled 1,0,0,1 repeating -> exact sequence 000000..070707 with no loss or duplication.
  - out_pix stays stable while out_valid=1 and out_ready=0.
  - mem_rd_en never asserts when occupancy would exceed 2.
- Stall at start: out_ready=0 for 10 cycles after start -> exactly 2 reads issued (addr 0,1), FIFO holds 2 entries.
  - On release, pixels 000000 then 010101 are delivered first.
- start ignored while busy: extra start pulse mid-frame -> one frame only, one done pulse, mem_addr never restarts at 0.
- Async reset mid-frame: assert rst between clock edges after 3 pixels.
  - out_valid, busy, and mem_rd_en go 0 immediately, without waiting for a clock edge.
  - After release, a new start streams the full frame from address 0 with sof set.
- Back-to-back frames: start asserted the cycle after done -> second frame identical to the first, sof re-asserted on pixel 0.
